// File: rtl/branch_predictor_pkg.sv
// Shared types, constants and helpers for the BTB branch predictor.
// Counter reset/allocate values and the saturating step live here.
package branch_predictor_pkg;

    localparam int DEF_ENTRIES = 64;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_CTR_W   = 2;

    typedef enum logic [1:0] {
        CTR_HOLD,
        CTR_INC,
        CTR_DEC,
        CTR_ALLOC
    } ctr_op_e;

    function automatic int unsigned idx_width(int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned tag_width(int unsigned addr_w,
                                              int unsigned entries);
        return addr_w - $clog2(entries) - 2;
    endfunction

    // Weakly not-taken: 01..1
    function automatic int unsigned ctr_reset_val(int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Weakly taken: 10..0
    function automatic int unsigned ctr_alloc_val(int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned sat_step(int unsigned cur,
                                             int unsigned w,
                                             ctr_op_e     op);
        int unsigned top;
        int unsigned res;
        top = (32'd1 << w) - 32'd1;
        res = cur;
        unique case (op)
            CTR_INC:   res = (cur == top) ? cur : cur + 32'd1;
            CTR_DEC:   res = (cur == 32'd0) ? cur : cur - 32'd1;
            CTR_ALLOC: res = ctr_alloc_val(w);
            default:   res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter_array.sv
// sat_counter_array: per-entry saturating counters with async reset.
// One combinational read port, one saturating write port.
module sat_counter_array
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int CTR_W   = DEF_CTR_W,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [CTR_W-1:0] rd_ctr_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [1:0]       wr_op_i
);

    localparam logic [CTR_W-1:0] RST_VAL =
        CTR_W'(ctr_reset_val(CTR_W));

    logic [CTR_W-1:0] ctr_q [ENTRIES];
    logic [CTR_W-1:0] ctr_d;

    // Next value of the entry being written
    always_comb begin
        ctr_d = CTR_W'(sat_step(32'(ctr_q[wr_idx_i]), CTR_W,
                                ctr_op_e'(wr_op_i)));
    end

    // Counter storage; reset returns every entry to weakly not-taken
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= RST_VAL;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= ctr_d;
        end
    end

    assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating counters.
// Define BP_GSHARE_EN to index counters by pc index XOR global history.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CTR_W   = DEF_CTR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic              pred_hit,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc
);

    localparam int IDX_W = idx_width(ENTRIES);
    localparam int TAG_W = tag_width(ADDR_W, ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    logic [IDX_W-1:0] ctr_rd_idx;
    logic [IDX_W-1:0] ctr_wr_idx;
    logic [CTR_W-1:0] ctr_rd;
    ctr_op_e          ctr_op;
    logic             ctr_we;
    logic             tgt_we;
    logic             tag_we;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;

    // Shift in each resolved outcome
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) begin
            ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
        end
    end

    // Global history register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ctr_rd_idx = if_idx ^ ghr_q;
    assign ctr_wr_idx = upd_idx ^ ghr_q;
`else
    assign ctr_rd_idx = if_idx;
    assign ctr_wr_idx = upd_idx;
`endif

    // Decide what the resolving branch does to its entry
    always_comb begin
        ctr_op  = CTR_HOLD;
        tgt_we  = 1'b0;
        tag_we  = 1'b0;
        valid_d = valid_q;
        if (upd_valid) begin
            unique case (1'b1)
                upd_hit && upd_taken: begin
                    ctr_op = CTR_INC;
                    tgt_we = 1'b1;
                end
                upd_hit && !upd_taken: begin
                    ctr_op = CTR_DEC;
                end
                !upd_hit && upd_taken: begin
                    ctr_op           = CTR_ALLOC;
                    tgt_we           = 1'b1;
                    tag_we           = 1'b1;
                    valid_d[upd_idx] = 1'b1;
                end
                default: begin
                    ctr_op = CTR_HOLD;
                end
            endcase
        end
    end

    assign ctr_we = (ctr_op != CTR_HOLD);

    // Valid bits; cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and target arrays are never reset; valid gates them
    always_ff @(posedge clock) begin
        if (tgt_we) begin
            target_q[upd_idx] <= upd_target;
        end
        if (tag_we) begin
            tag_q[upd_idx] <= upd_tag;
        end
    end

    sat_counter_array #(
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .IDX_W   (IDX_W)
    ) u_ctr (
        .clock    (clock),
        .reset    (reset),
        .rd_idx_i (ctr_rd_idx),
        .rd_ctr_o (ctr_rd),
        .wr_en_i  (ctr_we),
        .wr_idx_i (ctr_wr_idx),
        .wr_op_i  (ctr_op)
    );

    // Lookup sees pre-update state; no bypass from the update port
    always_comb begin
        pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = pred_hit && ctr_rd[CTR_W-1];
        pred_target = pred_taken ? target_q[if_idx]
                                 : if_pc + ADDR_W'(4);
    end

    // Flush request and corrected fetch address
    always_comb begin
        mispredict  = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (64 entries, 32-bit PC).
// Directed tables plus random traffic against an array-based model.
module tb_branch_predictor;

    logic        clock;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        pred_hit;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    branch_predictor #(
        .ENTRIES (64),
        .ADDR_W  (32),
        .CTR_W   (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_hit        (pred_hit),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: plain integer arrays
    bit          m_valid [64];
    int unsigned m_tag   [64];
    int unsigned m_tgt   [64];
    int unsigned m_ctr   [64];
    int unsigned m_ghr;

    function automatic int unsigned pc_idx(logic [31:0] pc);
        return (pc / 4) % 64;
    endfunction

    function automatic int unsigned pc_tag(logic [31:0] pc);
        return pc / 256;
    endfunction

    function automatic int unsigned ctr_idx(logic [31:0] pc);
`ifdef BP_GSHARE_EN
        return pc_idx(pc) ^ m_ghr;
`else
        return pc_idx(pc);
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_ghr = 0;
    endfunction

    function automatic bit model_hit(logic [31:0] pc);
        return m_valid[pc_idx(pc)] && (m_tag[pc_idx(pc)] == pc_tag(pc));
    endfunction

    function automatic void model_update();
        int unsigned i;
        int unsigned c;
        bit          h;
        i = pc_idx(upd_pc);
        c = ctr_idx(upd_pc);
        h = model_hit(upd_pc);
        if (h && upd_taken) begin
            if (m_ctr[c] < 3) m_ctr[c] = m_ctr[c] + 1;
            m_tgt[i] = upd_target;
        end else if (h) begin
            if (m_ctr[c] > 0) m_ctr[c] = m_ctr[c] - 1;
        end else if (upd_taken) begin
            m_valid[i] = 1;
            m_tag[i]   = pc_tag(upd_pc);
            m_tgt[i]   = upd_target;
            m_ctr[c]   = 2;
        end
        m_ghr = ((m_ghr * 2) + (upd_taken ? 1 : 0)) % 64;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Compare every output with the model, then clock the update in
    task automatic cycle(string nm);
        bit          e_hit;
        bit          e_tk;
        logic [31:0] e_tgt;
        bit          e_mis;
        logic [31:0] e_red;
        #1;
        e_hit = model_hit(if_pc);
        e_tk  = e_hit && (m_ctr[ctr_idx(if_pc)] >= 2);
        e_tgt = e_tk ? m_tgt[pc_idx(if_pc)] : if_pc + 32'd4;
        e_mis = upd_valid && ((upd_pred_taken != upd_taken) ||
                (upd_taken && (upd_pred_target != upd_target)));
        e_red = upd_taken ? upd_target : upd_pc + 32'd4;
        chk({nm, ".hit"}, {31'd0, pred_hit}, {31'd0, e_hit});
        chk({nm, ".taken"}, {31'd0, pred_taken}, {31'd0, e_tk});
        chk({nm, ".target"}, pred_target, e_tgt);
        chk({nm, ".mispredict"}, {31'd0, mispredict}, {31'd0, e_mis});
        chk({nm, ".redirect"}, redirect_pc, e_red);
        if (upd_valid) model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic look(string nm, logic [31:0] pc, logic h,
                        logic t, logic [31:0] tgt);
        upd_valid = 1'b0;
        if_pc     = pc;
        #1;
        chk({nm, ".hit"}, {31'd0, pred_hit}, {31'd0, h});
        chk({nm, ".taken"}, {31'd0, pred_taken}, {31'd0, t});
        chk({nm, ".target"}, pred_target, tgt);
    endtask

    task automatic upd(logic v, logic [31:0] pc, logic t,
                       logic [31:0] tgt, logic pt, logic [31:0] ptgt);
        upd_valid       = v;
        upd_pc          = pc;
        upd_taken       = t;
        upd_target      = tgt;
        upd_pred_taken  = pt;
        upd_pred_target = ptgt;
    endtask

    task automatic sync();
        upd_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        if ($urandom_range(0, 9) == 0) begin
            p = 32'hFFFF_FFFC;
        end else begin
            p = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2);
        end
        return p;
    endfunction

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        t;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        mis;
        logic [31:0] red;
    } mvec_t;

    mvec_t mtab [8];

    initial begin
        mtab[0] = '{1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104, 1'b1, 32'h40};
        mtab[1] = '{1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h40};
        mtab[2] = '{1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h40};
        mtab[3] = '{1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h104};
        mtab[4] = '{1'b1, 32'h100, 1'b0, 32'h40, 1'b0, 32'h104, 1'b0, 32'h104};
        mtab[5] = '{1'b0, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h104};
        mtab[6] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0};
        mtab[7] = '{1'b1, 32'h100, 1'b0, 32'h40, 1'b0, 32'h999, 1'b0, 32'h104};

        reset = 1'b0;
        if_pc = 32'h100;
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;

        // Combinational mispredict table, state frozen by reset
        for (int i = 0; i < 8; i++) begin
            upd(mtab[i].v, mtab[i].pc, mtab[i].t, mtab[i].tgt,
                mtab[i].pt, mtab[i].ptgt);
            #1;
            chk($sformatf("mtab%0d.mispredict", i),
                {31'd0, mispredict}, {31'd0, mtab[i].mis});
            chk($sformatf("mtab%0d.redirect", i), redirect_pc, mtab[i].red);
        end
        look("rst_0x100", 32'h100, 1'b0, 1'b0, 32'h104);
        look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        chk("rst.mispredict", {31'd0, mispredict}, 32'd0);

        sync();
        reset = 1'b1;
        sync();

`ifndef BP_GSHARE_EN
        // Allocate, then walk the counter both ways
        if_pc = 32'h100;
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        cycle("alloc");
        look("alloc_look", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        cycle("nt1");
        look("nt1_look", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
        cycle("nt2");
        look("nt2_look", 32'h100, 1'b1, 1'b0, 32'h104);
        for (int k = 0; k < 5; k++) begin
            upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
            cycle($sformatf("tk%0d", k));
        end
        look("sat_look", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        cycle("sat_dn1");
        look("sat_dn1_look", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        cycle("sat_dn2");
        look("sat_dn2_look", 32'h100, 1'b1, 1'b0, 32'h104);
        sync();

        // Aliasing on index 0
        upd(1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h104);
        cycle("alias_a");
        upd(1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
        cycle("alias_b");
        look("alias_100", 32'h100, 1'b0, 1'b0, 32'h104);
        look("alias_200", 32'h200, 1'b1, 1'b1, 32'h400);
        sync();

        // Same-cycle lookup and update: old counter visible
        if_pc = 32'h200;
        upd(1'b1, 32'h200, 1'b0, 32'h400, 1'b1, 32'h400);
        #1;
        chk("same_cycle.taken", {31'd0, pred_taken}, 32'd1);
        cycle("same_cycle");
        look("same_cycle_after", 32'h200, 1'b1, 1'b0, 32'h204);
        sync();
`else
        // Alternating history trains two distinct counters
        if_pc = 32'h100;
        for (int k = 0; k < 16; k++) begin
            upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
            cycle($sformatf("gs_t%0d", k));
            upd(1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
            cycle($sformatf("gs_n%0d", k));
        end
        look("gs_after_n", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        cycle("gs_last_t");
        look("gs_after_t", 32'h100, 1'b1, 1'b0, 32'h104);
        sync();
`endif

        // Async reset in the middle of an update cycle
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        cycle("pre_rst");
        if_pc = 32'h100;
        upd(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid.hit", {31'd0, pred_hit}, 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        look("rst_mid_500", 32'h500, 1'b0, 1'b0, 32'h504);
        look("rst_mid_100", 32'h100, 1'b0, 1'b0, 32'h104);
        sync();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] p;
            logic [31:0] t;
            p = rand_pc();
            t = $urandom & 32'hFFFF_FFFC;
            if_pc = rand_pc();
            upd($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0,
                t, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 1) == 1) ? t : p + 32'd4);
            cycle($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
